// File: rtl/winograd_pkg.sv
// Shared types and constants for the Winograd F(4x4,3x3) kernel transform.
package winograd_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned TAPS     = 3;
    localparam int unsigned TILE     = 6;

    typedef logic signed [DATA_W-1:0] data_t;
    typedef data_t [TILE-1:0]              vec6_t;
    typedef data_t [TAPS-1:0][TAPS-1:0]    kernel_t;
    typedef data_t [TILE-1:0][TAPS-1:0]    mid_t;
    typedef data_t [TILE-1:0][TILE-1:0]    tile_t;

    // G has only 0, +-1, +-2 and 4 entries; 2 and 4 are applied as shifts.
    localparam int unsigned G_X2_SHIFT = 1;
    localparam int unsigned G_X4_SHIFT = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_ROW  = 2'd2;
    localparam logic [1:0] ST_COL  = 2'd3;

endpackage

// File: rtl/kernel_transform_unit_if.sv
// Request/result bundle between the kernel source and the transform unit.
interface kernel_transform_unit_if
    import winograd_pkg::*;
;
    logic    start;
    kernel_t kernel_in;
    tile_t   kernel_out;
    logic    transform_done;

    modport master (output start, kernel_in, input kernel_out, transform_done);
    modport slave  (input start, kernel_in, output kernel_out, transform_done);
endinterface

// File: rtl/winograd_g_vec.sv
// 1-D G transform: three taps to six points {0,1,-1,2,-2,inf}, wrapping arithmetic.
module winograd_g_vec
    import winograd_pkg::*;
(
    input  data_t a,
    input  data_t b,
    input  data_t c,
    output vec6_t t
);

    data_t b2;
    data_t c4;

    assign b2 = data_t'(b <<< G_X2_SHIFT);
    assign c4 = data_t'(c <<< G_X4_SHIFT);

    // Evaluate every G row against the tap vector.
    always_comb begin
        t[0] = a;
        t[1] = a + b + c;
        t[2] = a - b + c;
        t[3] = a + b2 + c4;
        t[4] = a - b2 + c4;
        t[5] = c;
    end

endmodule

// File: rtl/kernel_transform_unit.sv
// Winograd kernel transform U = G * g * G^T, fixed 3-cycle latency after start.
module kernel_transform_unit
    import winograd_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    kernel_transform_unit_if.slave  bus
);

    logic [1:0] state;
    logic [1:0] state_next;

    kernel_t g_reg;
    mid_t    t_reg;
    mid_t    t_next;
    tile_t   u_next;
    tile_t   kernel_out_q;
    logic    done_q;
    vec6_t   row_vec [TAPS];

    // Row pass: each column of g through G gives one column of T.
    for (genvar j = 0; j < int'(TAPS); j++) begin : g_row_pass
        winograd_g_vec u_row (
            .a (g_reg[0][j]),
            .b (g_reg[1][j]),
            .c (g_reg[2][j]),
            .t (row_vec[j])
        );
    end

    // Regroup row-pass results into T[row][col].
    always_comb begin
        t_next = '0;
        for (int i = 0; i < int'(TILE); i++) begin
            for (int j = 0; j < int'(TAPS); j++) begin
                t_next[i][j] = row_vec[j][i];
            end
        end
    end

    // Column pass: each row of T through G gives one row of U.
    for (genvar i = 0; i < int'(TILE); i++) begin : g_col_pass
        winograd_g_vec u_col (
            .a (t_reg[i][0]),
            .b (t_reg[i][1]),
            .c (t_reg[i][2]),
            .t (u_next[i])
        );
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start only matters in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.start) state_next = ST_LOAD;
            ST_LOAD: state_next = ST_ROW;
            ST_ROW:  state_next = ST_COL;
            ST_COL:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath registers: capture kernel, hold T, publish U with a one-cycle done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_reg        <= '0;
            t_reg        <= '0;
            kernel_out_q <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= (state == ST_COL);
            if (state == ST_IDLE && bus.start) begin
                g_reg <= bus.kernel_in;
            end
            if (state == ST_LOAD || state == ST_ROW) begin
                t_reg <= t_next;
            end
            if (state == ST_COL) begin
                kernel_out_q <= u_next;
            end
        end
    end

    assign bus.kernel_out     = kernel_out_q;
    assign bus.transform_done = done_q;

endmodule

// File: tb/tb_kernel_transform_unit.sv
// Directed bench for the Winograd kernel transform unit.
module tb_kernel_transform_unit;
    import winograd_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    kernel_transform_unit_if bus ();

    kernel_transform_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic kernel_t mk9(input int a0, input int a1, input int a2,
                                    input int a3, input int a4, input int a5,
                                    input int a6, input int a7, input int a8);
        kernel_t k;
        k[0][0] = data_t'(a0); k[0][1] = data_t'(a1); k[0][2] = data_t'(a2);
        k[1][0] = data_t'(a3); k[1][1] = data_t'(a4); k[1][2] = data_t'(a5);
        k[2][0] = data_t'(a6); k[2][1] = data_t'(a7); k[2][2] = data_t'(a8);
        return k;
    endfunction

    // Issue one request, scramble kernel_in afterwards, count negedges until done.
    task automatic run(input kernel_t k, output int lat);
        @(negedge clk);
        bus.kernel_in = k;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.kernel_in = '1;
        lat = 0;
        while (bus.transform_done !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.kernel_in = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.kernel_out !== '0) begin
            errors++; $display("FAIL reset_out got nonzero tile exp zero");
        end
        checks++;
        if (bus.transform_done !== 1'b0) begin
            errors++; $display("FAIL reset_done got %b exp 0", bus.transform_done);
        end
        rst = 1'b0;
    endtask

    task automatic test_identity();
        int lat;
        int v[6] = '{0, 1, -1, 2, -2, 0};
        data_t exp_v;
        run(mk9(0,0,0, 0,1,0, 0,0,0), lat);
        checks++;
        if (lat != 3) begin
            errors++; $display("FAIL ident_latency got %0d exp 3", lat);
        end
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
                exp_v = data_t'(v[i] * v[j]);
                checks++;
                if (bus.kernel_out[i][j] !== exp_v) begin
                    errors++;
                    $display("FAIL ident_u%0d%0d got %0d exp %0d", i, j, bus.kernel_out[i][j], exp_v);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (bus.transform_done !== 1'b0) begin
            errors++; $display("FAIL done_one_cycle got %b exp 0", bus.transform_done);
        end
    endtask

    task automatic test_ones();
        int lat;
        run(mk9(1,1,1, 1,1,1, 1,1,1), lat);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL ones_latency got %0d exp 3", lat); end
        checks++;
        if (bus.kernel_out[0][0] !== 32'sd1) begin errors++; $display("FAIL ones_u00 got %0d exp 1", bus.kernel_out[0][0]); end
        checks++;
        if (bus.kernel_out[1][1] !== 32'sd9) begin errors++; $display("FAIL ones_u11 got %0d exp 9", bus.kernel_out[1][1]); end
        checks++;
        if (bus.kernel_out[3][3] !== 32'sd49) begin errors++; $display("FAIL ones_u33 got %0d exp 49", bus.kernel_out[3][3]); end
        checks++;
        if (bus.kernel_out[1][3] !== 32'sd21) begin errors++; $display("FAIL ones_u13 got %0d exp 21", bus.kernel_out[1][3]); end
        checks++;
        if (bus.kernel_out[5][5] !== 32'sd1) begin errors++; $display("FAIL ones_u55 got %0d exp 1", bus.kernel_out[5][5]); end
    endtask

    task automatic test_sequential();
        int lat;
        run(mk9(1,2,3, 4,5,6, 7,8,9), lat);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL seq_latency got %0d exp 3", lat); end
        checks++;
        if (bus.kernel_out[0][0] !== 32'sd1) begin errors++; $display("FAIL seq_u00 got %0d exp 1", bus.kernel_out[0][0]); end
        checks++;
        if (bus.kernel_out[0][5] !== 32'sd3) begin errors++; $display("FAIL seq_u05 got %0d exp 3", bus.kernel_out[0][5]); end
        checks++;
        if (bus.kernel_out[5][0] !== 32'sd7) begin errors++; $display("FAIL seq_u50 got %0d exp 7", bus.kernel_out[5][0]); end
        checks++;
        if (bus.kernel_out[5][5] !== 32'sd9) begin errors++; $display("FAIL seq_u55 got %0d exp 9", bus.kernel_out[5][5]); end
        checks++;
        if (bus.kernel_out[1][1] !== 32'sd45) begin errors++; $display("FAIL seq_u11 got %0d exp 45", bus.kernel_out[1][1]); end
    endtask

    task automatic test_edge_sobel();
        int lat;
        run(mk9(-1,-1,-1, -1,8,-1, -1,-1,-1), lat);
        checks++;
        if (bus.kernel_out[1][1] !== 32'sd0) begin errors++; $display("FAIL edge_u11 got %0d exp 0", bus.kernel_out[1][1]); end
        checks++;
        if (bus.kernel_out[0][0] !== -32'sd1) begin errors++; $display("FAIL edge_u00 got %0d exp -1", bus.kernel_out[0][0]); end
        checks++;
        if (bus.kernel_out[5][5] !== -32'sd1) begin errors++; $display("FAIL edge_u55 got %0d exp -1", bus.kernel_out[5][5]); end
        run(mk9(-1,0,1, -2,0,2, -1,0,1), lat);
        checks++;
        if (bus.kernel_out[1][1] !== 32'sd0) begin errors++; $display("FAIL sobel_u11 got %0d exp 0", bus.kernel_out[1][1]); end
        checks++;
        if (bus.kernel_out[0][0] !== -32'sd1) begin errors++; $display("FAIL sobel_u00 got %0d exp -1", bus.kernel_out[0][0]); end
        checks++;
        if (bus.kernel_out[0][5] !== 32'sd1) begin errors++; $display("FAIL sobel_u05 got %0d exp 1", bus.kernel_out[0][5]); end
    endtask

    task automatic test_wrap();
        int lat;
        int m = 32'h7FFF_FFFF;
        run(mk9(m,m,m, m,m,m, m,m,m), lat);
        checks++;
        if (bus.kernel_out[0][0] !== 32'sh7FFF_FFFF) begin errors++; $display("FAIL wrap_u00 got %h exp 7fffffff", bus.kernel_out[0][0]); end
        checks++;
        if (bus.kernel_out[1][1] !== 32'sh7FFF_FFF7) begin errors++; $display("FAIL wrap_u11 got %h exp 7ffffff7", bus.kernel_out[1][1]); end
        checks++;
        if (bus.kernel_out[3][3] !== 32'sh7FFF_FFCF) begin errors++; $display("FAIL wrap_u33 got %h exp 7fffffcf", bus.kernel_out[3][3]); end
    endtask

    task automatic test_busy_start();
        int pulses = 0;
        @(negedge clk);
        bus.kernel_in = mk9(1,1,1, 1,1,1, 1,1,1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.kernel_in = mk9(0,0,0, 0,1,0, 0,0,0);
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.transform_done !== 1'b1) begin errors++; $display("FAIL busy_done got %b exp 1", bus.transform_done); end
        checks++;
        if (bus.kernel_out[3][3] !== 32'sd49) begin errors++; $display("FAIL busy_u33 got %0d exp 49", bus.kernel_out[3][3]); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.transform_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL busy_extra_done got %0d exp 0", pulses); end
    endtask

    task automatic test_back_to_back();
        int lat;
        run(mk9(1,2,3, 4,5,6, 7,8,9), lat);
        bus.kernel_in = mk9(1,1,1, 1,1,1, 1,1,1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.kernel_in = '0;
        checks++;
        if (bus.transform_done !== 1'b0) begin errors++; $display("FAIL b2b_done_low got %b exp 0", bus.transform_done); end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.transform_done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b exp 1", bus.transform_done); end
        checks++;
        if (bus.kernel_out[3][3] !== 32'sd49) begin errors++; $display("FAIL b2b_u33 got %0d exp 49", bus.kernel_out[3][3]); end
    endtask

    task automatic test_stability();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.kernel_in = mk9(c,7,c,3,c,9,c,1,c);
        end
        checks++;
        if (bus.kernel_out[3][3] !== 32'sd49) begin errors++; $display("FAIL hold_u33 got %0d exp 49", bus.kernel_out[3][3]); end
        checks++;
        if (bus.kernel_out[1][1] !== 32'sd9) begin errors++; $display("FAIL hold_u11 got %0d exp 9", bus.kernel_out[1][1]); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        int lat;
        @(negedge clk);
        bus.kernel_in = mk9(1,2,3, 4,5,6, 7,8,9);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.kernel_out !== '0) begin errors++; $display("FAIL midrst_out got nonzero tile exp zero"); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.transform_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL midrst_done got %0d exp 0", pulses); end
        checks++;
        if (bus.kernel_out !== '0) begin errors++; $display("FAIL midrst_hold got nonzero tile exp zero"); end
        run(mk9(1,1,1, 1,1,1, 1,1,1), lat);
        checks++;
        if (lat != 3 || bus.kernel_out[1][1] !== 32'sd9) begin
            errors++; $display("FAIL midrst_recover got lat %0d u11 %0d exp lat 3 u11 9", lat, bus.kernel_out[1][1]);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_ones();
        test_sequential();
        test_edge_sobel();
        test_wrap();
        test_busy_start();
        test_back_to_back();
        test_stability();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
